// File: rtl/chi_txnid_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// chi_txnid_alloc_ctrl
//
// Purpose:
//   Shares a fixed pool of CHI TxnIDs between NUM_REQ request-generating
//   agents. A round-robin arbiter picks one requester per cycle and that
//   requester receives the lowest-numbered free ID. IDs go back to the pool
//   when they are freed. IDs marked in RSVD_MASK are never handed out. A
//   sticky error flag records illegal frees.
//
// Handshake (valid/ready):
//   A requester raises req_valid[n] and holds it until it sees req_gnt[n]
//   high. The grant is combinational from registered state, so the
//   requester sees it in the same cycle. The ID is consumed at the clock
//   edge that ends a cycle in which req_gnt[n] is high. If a requester drops
//   req_valid early, it is simply not granted. free_valid is a
//   single-cycle, always-accepted strobe.
//
// Optional feature (macro CHI_SS_COMPACK_HOLD_EN):
//   When the macro is defined, an ID returns to the pool only after both
//   free_valid (completion) and compack_valid (CompAck) have been seen for
//   it, in either order. The two events may also arrive in the same cycle.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   req_valid      in   [NUM_REQ]  per-requester allocation request
//   req_gnt        out  [NUM_REQ]  one-hot grant for this cycle
//   gnt_id         out  [ID_W]     granted ID, valid when |req_gnt
//   free_valid     in   return (completion) strobe
//   free_id        in   [ID_W]     ID being returned
//   compack_valid  in   CompAck strobe        (macro builds only)
//   compack_id     in   [ID_W]     CompAck ID (macro builds only)
//   free_count     out  number of currently allocatable IDs
//   pool_empty     out  free_count == 0
//   err_bad_free   out  sticky illegal-free flag
// ---------------------------------------------------------------------------
module chi_txnid_alloc_ctrl #(
    parameter int                 NUM_REQ   = 4,
    parameter int                 NUM_IDS   = 16,
    parameter int                 ID_W      = 8,
    parameter logic [NUM_IDS-1:0] RSVD_MASK = 16'h022A
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_gnt,
    output logic [ID_W-1:0]              gnt_id,
    input  logic                         free_valid,
    input  logic [ID_W-1:0]              free_id,
`ifdef CHI_SS_COMPACK_HOLD_EN
    input  logic                         compack_valid,
    input  logic [ID_W-1:0]              compack_id,
`endif
    output logic [$clog2(NUM_IDS+1)-1:0] free_count,
    output logic                         pool_empty,
    output logic                         err_bad_free
);

    localparam int CNT_W = $clog2(NUM_IDS + 1);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // State
    logic [NUM_IDS-1:0] r_bitmap;   // 1 = free and allocatable
    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_err;

    // Arbitration
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_winner;
    logic               w_found;
    logic               w_gnt;
    logic [PTR_W-1:0]   w_rr_nxt;

    // ID selection
    logic [ID_W-1:0]    w_low_id;
    logic [NUM_IDS-1:0] w_low_oh;
    logic [NUM_IDS-1:0] w_gnt_oh;

    // Return path
    logic [NUM_IDS-1:0] w_free_oh;
    logic [NUM_IDS-1:0] w_release;
    logic               w_bad;
    logic [CNT_W-1:0]   w_cnt;

    // Round-robin search starting at r_rr_ptr; the first valid requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Lowest set bit of the bitmap. The scan runs from high to low so that
    // the last assignment is the lowest free ID.
    always_comb begin
        w_low_id = '0;
        w_low_oh = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (r_bitmap[i]) begin
                w_low_id = ID_W'(i);
                w_low_oh = '0;
                w_low_oh[i] = 1'b1;
            end
        end
    end

    assign w_gnt    = w_found && (|r_bitmap);
    assign w_gnt_oh = w_gnt ? w_low_oh : '0;
    assign w_rr_nxt = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;

    always_comb begin
        req_gnt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_gnt[j] = w_gnt && (w_winner == PTR_W'(j));
        end
    end

    assign gnt_id = w_gnt ? w_low_id : '0;

    // Decode free_id against the pool. An ID outside the pool matches no bit.
    always_comb begin
        w_free_oh = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            w_free_oh[i] = free_valid && (free_id == ID_W'(i));
        end
    end

`ifdef CHI_SS_COMPACK_HOLD_EN
    // Per-ID tracking of the two return events for allocated IDs.
    logic [NUM_IDS-1:0] r_comp_seen;
    logic [NUM_IDS-1:0] r_ack_seen;
    logic [NUM_IDS-1:0] w_ack_oh;
    logic [NUM_IDS-1:0] w_comp_ok;
    logic [NUM_IDS-1:0] w_ack_ok;
    logic [NUM_IDS-1:0] w_comp_nxt;
    logic [NUM_IDS-1:0] w_ack_nxt;
    logic               w_comp_bad;
    logic               w_ack_bad;

    always_comb begin
        w_ack_oh = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            w_ack_oh[i] = compack_valid && (compack_id == ID_W'(i));
        end
    end

    // An event is legal only for an allocated (not free, not reserved) ID
    // that has not already seen the same event.
    assign w_comp_ok  = w_free_oh & ~RSVD_MASK & ~r_bitmap & ~r_comp_seen;
    assign w_ack_ok   = w_ack_oh  & ~RSVD_MASK & ~r_bitmap & ~r_ack_seen;
    assign w_comp_bad = free_valid    && ((w_free_oh == '0) || ((w_free_oh & ~w_comp_ok) != '0));
    assign w_ack_bad  = compack_valid && ((w_ack_oh  == '0) || ((w_ack_oh  & ~w_ack_ok)  != '0));
    assign w_comp_nxt = r_comp_seen | w_comp_ok;
    assign w_ack_nxt  = r_ack_seen  | w_ack_ok;
    assign w_release  = w_comp_nxt & w_ack_nxt;
    assign w_bad      = w_comp_bad | w_ack_bad;

    // A released ID has both bits cleared. Granting also clears the bits for
    // the new allocation, although they are already zero for a free ID.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_comp_seen <= '0;
            r_ack_seen  <= '0;
        end else begin
            r_comp_seen <= w_comp_nxt & ~w_release & ~w_gnt_oh;
            r_ack_seen  <= w_ack_nxt  & ~w_release & ~w_gnt_oh;
        end
    end
`else
    // A free is legal only for an ID that is in range, not reserved and
    // currently allocated. Reserved IDs sit at 0 in the bitmap, so they need
    // their own check.
    assign w_bad     = free_valid &&
                       ((w_free_oh == '0) || ((w_free_oh & (RSVD_MASK | r_bitmap)) != '0));
    assign w_release = w_bad ? '0 : w_free_oh;
`endif

    // Main state. A released ID is never the granted ID, because only
    // allocated IDs can be released and only free IDs can be granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitmap <= ~RSVD_MASK;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_bitmap <= (r_bitmap & ~w_gnt_oh) | w_release;
            if (w_gnt) begin
                r_rr_ptr <= w_rr_nxt;
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // free_count is the popcount of the bitmap, so it can neither overflow
    // nor underflow.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            w_cnt = w_cnt + CNT_W'(r_bitmap[i]);
        end
    end

    assign free_count   = w_cnt;
    assign pool_empty   = (r_bitmap == '0);
    assign err_bad_free = r_err;

endmodule

// File: doc/chi_txnid_alloc_ctrl.md
Name: chi_txnid_alloc_ctrl

Overview:
- Allocates CHI TxnIDs from a fixed pool and shares the pool between several request-generating agents inside the CHI AIU subsystem.
- Reserved IDs are never handed out.
- A round-robin arbiter picks one requester per cycle. The lowest free ID is granted. IDs return to the pool on completion.
- A sticky error flags illegal frees.

Parameters:
- NUM_REQ, 4, number of requesters arbitrated.
- NUM_IDS, 16, size of the TxnID pool; IDs 0..NUM_IDS-1.
- ID_W, 8, width of the ID fields; NUM_IDS <= 2**ID_W.
- RSVD_MASK, 16'h022A, bit i set means ID i is reserved and never allocated (default reserves 1, 3, 5, 9).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester allocation request; held until granted.
- req_gnt  out  NUM_REQ  one-hot grant for this cycle; zero or one bit set.
- gnt_id  out  ID_W  ID granted this cycle; valid when |req_gnt.
- free_valid  in  1  return an ID to the pool.
- free_id  in  ID_W  ID being returned.
- free_count  out  $clog2(NUM_IDS+1)  number of currently allocatable IDs.
- pool_empty  out  1  free_count==0.
- err_bad_free  out  1  sticky; set on a free of a reserved, out-of-range or already-free ID.

Behaviour:
- State:
  - free bitmap[NUM_IDS], where 1 means free.
  - rr_ptr[$clog2(NUM_REQ)].
  - err flag.
  - free_count register, or derived by popcount; either is acceptable if timing is met.
- Reset (async assert, sync deassert by the top level):
  - bitmap = ~RSVD_MASK.
  - rr_ptr = 0, err_bad_free = 0.
  - req_gnt = 0.
  - free_count = popcount(~RSVD_MASK) (12 at defaults).
  - pool_empty = 0.
- Reset mid-operation discards all outstanding IDs. The pool returns to the reset state.
- Grant is combinational from registered state in the same cycle, with zero-cycle latency from req_valid.
- A grant occurs only if at least one requester is valid and the bitmap is nonzero.
- Winner selection: first valid requester searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- gnt_id = lowest-index set bit of the bitmap.
- On grant, at the next edge:
  - bitmap[gnt_id] clears.
  - rr_ptr = winner+1 mod NUM_REQ.
- With no grant, rr_ptr holds.
- Requesters must keep req_valid high until their req_gnt bit is seen. A requester dropping req_valid early is legal; no grant is issued to it.
- Free: on free_valid with a legal ID, bitmap[free_id] sets at the next edge. The freed ID is not grantable in the same cycle, only from the next cycle.
- Illegal free (reserved, free_id >= NUM_IDS, or already free):
  - ignored, with no bitmap change;
  - err_bad_free set next cycle;
  - cleared only by reset.
- Simultaneous grant and free in one cycle:
  - both apply;
  - free_count net change is 0;
  - the granted ID and the freed ID are necessarily different.
- Pool empty: pool_empty=1, no grants, requests remain pending.
- free_count never exceeds popcount(~RSVD_MASK) and never underflows.

Optional Feature:
- Macro: CHI_SS_COMPACK_HOLD_EN.
- When defined:
  - Adds ports compack_valid (in, 1) and compack_id (in, ID_W).
  - An allocated ID returns to the pool only after both free_valid and compack_valid have been seen for it, in either order or in the same cycle.
  - Tracking uses per-ID bits comp_seen and ack_seen, cleared on grant. The ID is freed the cycle after the second event.
  - A duplicate comp or compack for an ID, or either event on a free or reserved ID, sets err_bad_free.
- When undefined:
  - The ports are absent.
  - free_valid alone returns the ID as described above.

Test Plan:
- Reset, then only req_valid[0] held for 4 cycles -> free_count=12 after reset; gnt_id 0,2,4,6 on consecutive cycles; free_count then 8.
- All req_valid=4'hF held -> req_gnt sequence 0001, 0010, 0100, 1000, 0001 with gnt_id 0,2,4,6,7.
- Twelve grants -> pool_empty=1, free_count=0, req_valid[2] held with no grant; free_id=7 at cycle N -> req_gnt[2]=1 with gnt_id=7 at N+1.
- Pool empty, free_id=4 and req_valid[1] in the same cycle N -> no grant at N; grant id 4 at N+1; free_count 1 then 0.
- free_id=3 (reserved), then free_id=0 while 0 is free -> err_bad_free=1 from the next cycle; bitmap and free_count unchanged; err stays set until reset_n low.
- CHI_SS_COMPACK_HOLD_EN: allocate ID 0, free 0 at cycle N, compack 0 at N+2 -> ID 0 not grantable at N+1..N+2, grantable at N+3; compack 0 repeated -> err_bad_free=1.
